// File: rtl/bcd_pkg.sv
// Shared constants, helper functions and FSM state type for the binary-to-BCD converters.
package bcd_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Digits needed to hold any w-bit unsigned value: smallest d with 10^d >= 2^w,
   // which equals ceil(w*log10(2)) for w >= 1.
   function automatic int unsigned bcd_digits(input int w);
      logic [63:0]  lim;
      logic [63:0]  p;
      int unsigned  d;
      lim = 64'd1 << w;
      p   = 64'd10;
      d   = 1;
      for (int i = 0; i < 20; i++) begin
         if (p < lim) begin
            p = p * 64'd10;
            d = d + 1;
         end
      end
      return d;
   endfunction

   // 10^n as a 64-bit constant; valid for n <= 19.
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Single BCD digit correction cell: adds 3 when the digit is 5 or more.
// Ports:
//   i_dig    digit before correction
//   o_dig_c  corrected digit (combinational)
module bcd_add3_digit (
   input  logic [3:0] i_dig,
   output logic [3:0] o_dig_c
);

   assign o_dig_c = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes,
// overflow saturation and a leading-zero blank mask for the seven-segment path.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_valid / o_ready     input handshake; o_ready high only while idle
//   i_data                unsigned binary value, sampled on the accept edge
//   o_valid / i_ready     result handshake; o_valid high only while done
//   o_bcd                 NUM_DIG BCD digits, digit 0 least significant
//   o_blank               bit k set when digit k is a leading zero (bit 0 never)
//   o_overflow            input >= 10^NUM_DIG, o_bcd saturated to all nines
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned IN_W    = 27,
   parameter int unsigned NUM_DIG = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [IN_W-1:0]        i_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [4*NUM_DIG-1:0]   o_bcd,
   output logic [NUM_DIG-1:0]     o_blank,
   output logic                   o_overflow
);

   localparam int unsigned NAT_DIG = bcd_digits(int'(IN_W));
   localparam int unsigned ACC_DIG = (NAT_DIG > NUM_DIG) ? NAT_DIG : NUM_DIG;
   localparam int unsigned ACC_W   = 4 * ACC_DIG;
   localparam int unsigned OUT_W   = 4 * NUM_DIG;
   localparam int unsigned CNT_W   = $clog2(IN_W + 1);
   localparam logic [63:0] OVF_LIM = pow10(int'(NUM_DIG));

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   w_load;
   logic                   w_last;

   logic [IN_W-1:0]        r_bin;
   logic [ACC_W-1:0]       r_acc;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_ovf;

   logic                   r_ready;
   logic                   r_valid;
   logic [OUT_W-1:0]       r_bcd;
   logic [NUM_DIG-1:0]     r_blank;
   logic                   r_ovf_out;

   logic [ACC_W-1:0]       w_adj;
   logic [ACC_W+IN_W-1:0]  w_cat;
   logic [OUT_W-1:0]       w_res;
   logic [NUM_DIG-1:0]     w_blank;
   logic                   w_run;
   logic                   w_ovf;

   // Per-digit add-3 correction ahead of each shift
   for (genvar g = 0; g < int'(ACC_DIG); g++) begin : g_add3
      bcd_add3_digit u_add3 (
         .i_dig   (r_acc[4*g +: 4]),
         .o_dig_c (w_adj[4*g +: 4])
      );
   end

   // Corrected accumulator and binary register shifted left as one vector
   assign w_cat = {w_adj, r_bin} << 1;
   assign w_res = w_cat[IN_W +: OUT_W];
   assign w_ovf = (64'(i_data) >= OVF_LIM);

   // Leading-zero mask: scan from the top digit down while digits stay zero
   always_comb begin
      w_blank = '0;
      w_run   = 1'b1;
      for (int k = int'(NUM_DIG) - 1; k >= 1; k--) begin
         w_run      = w_run & (w_res[4*k +: 4] == 4'd0);
         w_blank[k] = w_run;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and control decode
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_last      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_cnt == CNT_W'(1)) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (i_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin     <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_ready   <= 1'b1;
         r_valid   <= 1'b0;
         r_bcd     <= '0;
         r_blank   <= '0;
         r_ovf_out <= 1'b0;
      end else begin
         r_ready <= (w_state_nxt == S_IDLE);
         r_valid <= (w_state_nxt == S_DONE);
         if (w_load) begin
            r_bin <= i_data;
            r_acc <= '0;
            r_cnt <= CNT_W'(IN_W);
            r_ovf <= w_ovf;
         end else if (r_state == S_SHIFT) begin
            r_acc <= w_cat[IN_W +: ACC_W];
            r_bin <= w_cat[IN_W-1:0];
            r_cnt <= r_cnt - CNT_W'(1);
         end
         // Results are published only on the final shift edge
         if (w_last) begin
            r_bcd     <= r_ovf ? {NUM_DIG{4'h9}} : w_res;
            r_blank   <= r_ovf ? '0 : w_blank;
            r_ovf_out <= r_ovf;
         end
      end
   end

   assign o_ready    = r_ready;
   assign o_valid    = r_valid;
   assign o_bcd      = r_bcd;
   assign o_blank    = r_blank;
   assign o_overflow = r_ovf_out;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: default instance (27 bits, 8 digits)
// plus a small instance (8 bits, 3 digits), directed table and random values.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        m_valid, m_ready, m_ovalid, m_iready, m_ovf;
   logic [26:0] m_data;
   logic [31:0] m_bcd;
   logic [7:0]  m_blank;

   logic        s_valid, s_ready, s_ovalid, s_iready, s_ovf;
   logic [7:0]  s_data;
   logic [11:0] s_bcd;
   logic [2:0]  s_blank;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bin2bcd_seq u_main (
      .clk(clk), .rst_n(rst_n),
      .i_valid(m_valid), .o_ready(m_ready), .i_data(m_data),
      .o_valid(m_ovalid), .i_ready(m_iready),
      .o_bcd(m_bcd), .o_blank(m_blank), .o_overflow(m_ovf)
   );

   bin2bcd_seq #(.IN_W(8), .NUM_DIG(3)) u_small (
      .clk(clk), .rst_n(rst_n),
      .i_valid(s_valid), .o_ready(s_ready), .i_data(s_data),
      .o_valid(s_ovalid), .i_ready(s_iready),
      .o_bcd(s_bcd), .o_blank(s_blank), .o_overflow(s_ovf)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: decimal digits by division, saturation and blanking by magnitude
   function automatic void ref_model(input longint unsigned v, input int nd,
                                     output logic [39:0] bcd, output logic [9:0] blank,
                                     output logic ovf);
      longint unsigned p, t;
      p = 1;
      for (int i = 0; i < nd; i++) p = p * 10;
      ovf   = (v >= p);
      bcd   = '0;
      blank = '0;
      t     = v;
      for (int k = 0; k < nd; k++) begin
         bcd[4*k +: 4] = ovf ? 4'd9 : 4'(t % 10);
         t = t / 10;
      end
      p = 1;
      for (int k = 1; k < nd; k++) begin
         p = p * 10;
         blank[k] = !ovf && (v < p);
      end
   endfunction

   task automatic conv_main(input logic [26:0] d, input logic [31:0] eb, input logic [7:0] ebl,
                            input logic eo, input int hold, input string tag);
      int n;
      int w;
      @(negedge clk);
      w = 0;
      while (!m_ready && w < 200) begin @(negedge clk); w++; end
      chk({tag, " ready_in"}, 64'(m_ready), 64'd1);
      m_valid  = 1'b1;
      m_data   = d;
      m_iready = 1'b0;
      @(negedge clk);
      m_valid = 1'b0;
      m_data  = 27'($urandom);
      n = 1;
      while (!m_ovalid && n < 200) begin @(negedge clk); n++; end
      chk({tag, " latency"}, 64'(n), 64'd28);
      chk({tag, " bcd"}, 64'(m_bcd), 64'(eb));
      chk({tag, " blank"}, 64'(m_blank), 64'(ebl));
      chk({tag, " ovf"}, 64'(m_ovf), 64'(eo));
      if (hold > 0) begin
         m_valid = 1'b1;
         m_data  = 27'd555;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold_valid"}, 64'(m_ovalid), 64'd1);
            chk({tag, " hold_ready"}, 64'(m_ready), 64'd0);
            chk({tag, " hold_bcd"}, 64'(m_bcd), 64'(eb));
            chk({tag, " hold_blank"}, 64'(m_blank), 64'(ebl));
         end
         m_valid = 1'b0;
      end
      m_iready = 1'b1;
      @(negedge clk);
      m_iready = 1'b0;
      chk({tag, " valid_drop"}, 64'(m_ovalid), 64'd0);
      chk({tag, " ready_back"}, 64'(m_ready), 64'd1);
      chk({tag, " bcd_kept"}, 64'(m_bcd), 64'(eb));
   endtask

   task automatic conv_small(input logic [7:0] d, input string tag);
      int n;
      int w;
      logic [39:0] eb;
      logic [9:0]  ebl;
      logic        eo;
      ref_model(64'(d), 3, eb, ebl, eo);
      @(negedge clk);
      w = 0;
      while (!s_ready && w < 200) begin @(negedge clk); w++; end
      s_valid  = 1'b1;
      s_data   = d;
      s_iready = 1'b0;
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      n = 1;
      while (!s_ovalid && n < 200) begin @(negedge clk); n++; end
      chk({tag, " latency"}, 64'(n), 64'd9);
      chk({tag, " bcd"}, 64'(s_bcd), 64'(eb[11:0]));
      chk({tag, " blank"}, 64'(s_blank), 64'(ebl[2:0]));
      chk({tag, " ovf"}, 64'(s_ovf), 64'(eo));
      s_iready = 1'b1;
      @(negedge clk);
      s_iready = 1'b0;
      chk({tag, " ready_back"}, 64'(s_ready), 64'd1);
   endtask

   typedef struct {
      logic [26:0] d;
      logic [31:0] bcd;
      logic [7:0]  blank;
      logic        ovf;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] eb;
      logic [9:0]  ebl;
      logic        eo;
      logic [26:0] d;

      vecs[0] = '{27'd0,         32'h00000000, 8'hFE, 1'b0};
      vecs[1] = '{27'd12345678,  32'h12345678, 8'h00, 1'b0};
      vecs[2] = '{27'd99999999,  32'h99999999, 8'h00, 1'b0};
      vecs[3] = '{27'd100000000, 32'h99999999, 8'h00, 1'b1};
      vecs[4] = '{27'd134217727, 32'h99999999, 8'h00, 1'b1};
      vecs[5] = '{27'd9,         32'h00000009, 8'hFE, 1'b0};
      vecs[6] = '{27'd10,        32'h00000010, 8'hFC, 1'b0};
      vecs[7] = '{27'd1000,      32'h00001000, 8'hF0, 1'b0};

      rst_n = 1'b0;
      m_valid = 1'b0; m_data = '0; m_iready = 1'b0;
      s_valid = 1'b0; s_data = '0; s_iready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst ready", 64'(m_ready), 64'd1);
      chk("rst valid", 64'(m_ovalid), 64'd0);
      chk("rst bcd", 64'(m_bcd), 64'd0);
      chk("rst blank", 64'(m_blank), 64'd0);
      chk("rst ovf", 64'(m_ovf), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         conv_main(vecs[i].d, vecs[i].bcd, vecs[i].blank, vecs[i].ovf, 0,
                   $sformatf("vec%0d", i));
      end

      // Back-pressure with an ignored request during the hold
      conv_main(27'd42, 32'h00000042, 8'hFC, 1'b0, 10, "hold42");
      repeat (3) begin
         @(negedge clk);
         chk("no_queue valid", 64'(m_ovalid), 64'd0);
      end

      // Reset in the middle of a conversion
      m_valid = 1'b1;
      m_data  = 27'd777;
      @(negedge clk);
      m_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("mid valid", 64'(m_ovalid), 64'd0);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("async ready", 64'(m_ready), 64'd1);
      chk("async valid", 64'(m_ovalid), 64'd0);
      chk("async bcd", 64'(m_bcd), 64'd0);
      chk("async blank", 64'(m_blank), 64'd0);
      chk("async ovf", 64'(m_ovf), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst valid", 64'(m_ovalid), 64'd0);
      end
      conv_main(27'd5, 32'h00000005, 8'hFE, 1'b0, 0, "after_rst");

      // Random values, with extra weight near the overflow boundary
      for (int i = 0; i < 30; i++) begin
         if (i % 4 == 0) d = 27'(100000000 - 2 + $urandom_range(0, 3));
         else            d = 27'($urandom);
         ref_model(64'(d), 8, eb, ebl, eo);
         conv_main(d, eb[31:0], ebl[7:0], eo, 0, $sformatf("rnd%0d_%0d", i, d));
      end

      // Small instance
      conv_small(8'd255, "s255");
      conv_small(8'd7, "s7");
      chk("s7 blank_const", 64'(s_blank), 64'(3'b110));
      conv_small(8'd0, "s0");
      for (int i = 0; i < 10; i++) begin
         d = 27'($urandom_range(0, 255));
         conv_small(8'(d), $sformatf("srnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
